// File: rtl/alif_multi_channel_core.sv
// alif_multi_channel_core: multi-channel adaptive leaky integrate-and-fire neuron.
// A serial shift register loads weights, threshold, adaptation, leak, decay and
// refractory settings. On a complete load they are copied into the active set.
// The optional macro ALIF_SPIKE_COUNTER_EN adds a saturating 16-bit spike_count output.
module alif_multi_channel_core #(
  parameter int N_CH = 4,
  parameter int IN_W = 6,
  parameter int W_W  = 4,
  parameter int VW   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   input_enable,
  input  logic [N_CH*IN_W-1:0]   chan_in,
  input  logic                   load_mode,
  input  logic                   serial_data,
  output logic                   spike_out,
  output logic [VW-1:0]          v_mem_out,
  output logic                   params_ready,
  output logic                   in_refrac
`ifdef ALIF_SPIKE_COUNTER_EN
  ,
  output logic [15:0]            spike_count
`endif
);

  // Configuration word layout, MSB to LSB: weights, base_th, adapt_inc(4), leak_sh(3), decay_sh(3), refrac(4).
  localparam int CFG_BITS = N_CH*W_W + VW + 14;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam int SUM_W    = IN_W + W_W + $clog2(N_CH) + 1;
  localparam int EXT_W    = ((SUM_W > VW) ? SUM_W : VW) + 1;

  typedef enum logic [1:0] {UNCONFIG, LOAD, RUN, REFRAC} state_t;

  state_t                state, state_next;
  logic [CFG_BITS-1:0]   shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [N_CH*W_W-1:0]   w_act;
  logic [VW-1:0]         base_th;
  logic [3:0]            adapt_inc;
  logic [2:0]            leak_sh;
  logic [2:0]            decay_sh;
  logic [3:0]            refrac;
  logic [3:0]            rcnt;
  logic [VW-1:0]         v;
  logic [VW-1:0]         adapt;

  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      i_term;
  logic [VW-1:0]         leak;
  logic [VW-1:0]         v_next;
  logic [VW-1:0]         th;
  logic [VW-1:0]         a_inc;
  logic [VW-1:0]         a_dec;
  logic                  fire;
  logic                  cfg_full;

  function automatic logic [VW-1:0] sat_vw(input logic [EXT_W-1:0] x);
    if ((x >> VW) != '0) return '1;
    else return x[VW-1:0];
  endfunction

  function automatic logic [VW-1:0] decay(input logic [VW-1:0] x, input logic [2:0] sh);
    logic [VW-1:0] d;
    d = x >> sh;
    if (sh == 3'd0) return x;
    else if (d == '0 && x != '0) return x - VW'(1);
    else return x - d;
  endfunction

  // Neuron datapath: weighted input sum, leak, saturated membrane and threshold
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + SUM_W'(chan_in[i*IN_W +: IN_W]) * SUM_W'(w_act[i*W_W +: W_W]);
    end
    i_term   = sum >> 4;
    leak     = (leak_sh == 3'd0) ? '0 : (v >> leak_sh);
    v_next   = sat_vw(EXT_W'(v - leak) + EXT_W'(i_term));
    th       = sat_vw(EXT_W'(base_th) + EXT_W'(adapt));
    a_inc    = sat_vw(EXT_W'(adapt) + EXT_W'(adapt_inc));
    a_dec    = decay(adapt, decay_sh);
    fire     = (v_next >= th);
    cfg_full = (bit_cnt == CNT_W'(CFG_BITS));
  end

  // Next-state logic; load_mode pre-empts every other transition
  always_comb begin
    state_next = state;
    if (enable) begin
      if (load_mode) begin
        state_next = LOAD;
      end else begin
        case (state)
          LOAD:     state_next = (cfg_full || params_ready) ? RUN : UNCONFIG;
          RUN:      if (input_enable && fire && refrac != 4'd0) state_next = REFRAC;
          REFRAC:   if (input_enable && rcnt == 4'd1) state_next = RUN;
          default:  state_next = state;
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= UNCONFIG;
    else       state <= state_next;
  end

  // Configuration shifting, parameter transfer and neuron state update
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      w_act        <= '0;
      base_th      <= '0;
      adapt_inc    <= '0;
      leak_sh      <= '0;
      decay_sh     <= '0;
      refrac       <= '0;
      rcnt         <= '0;
      v            <= '0;
      adapt        <= '0;
      spike_out    <= 1'b0;
      params_ready <= 1'b0;
`ifdef ALIF_SPIKE_COUNTER_EN
      spike_count  <= '0;
`endif
    end else begin
      spike_out <= 1'b0;
      if (enable) begin
        if (load_mode) begin
          shreg <= {shreg[CFG_BITS-2:0], serial_data};
          // The first shifted bit restarts the count on LOAD entry
          if (state != LOAD) bit_cnt <= CNT_W'(1);
          else if (!cfg_full) bit_cnt <= bit_cnt + CNT_W'(1);
        end else begin
          case (state)
            LOAD: begin
              if (cfg_full) begin
                w_act        <= shreg[CFG_BITS-1 -: N_CH*W_W];
                base_th      <= shreg[14 +: VW];
                adapt_inc    <= shreg[13:10];
                leak_sh      <= shreg[9:7];
                decay_sh     <= shreg[6:4];
                refrac       <= shreg[3:0];
                v            <= '0;
                adapt        <= '0;
                params_ready <= 1'b1;
`ifdef ALIF_SPIKE_COUNTER_EN
                spike_count  <= '0;
`endif
              end
            end
            RUN: begin
              if (input_enable) begin
                if (fire) begin
                  spike_out <= 1'b1;
                  v         <= '0;
                  adapt     <= a_inc;
                  rcnt      <= refrac;
`ifdef ALIF_SPIKE_COUNTER_EN
                  if (spike_count != 16'hFFFF) spike_count <= spike_count + 16'd1;
`endif
                end else begin
                  v     <= v_next;
                  adapt <= a_dec;
                end
              end
            end
            REFRAC: begin
              if (input_enable) begin
                v     <= '0;
                adapt <= a_dec;
                rcnt  <= rcnt - 4'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign v_mem_out = v;
  assign in_refrac = (state == REFRAC);

endmodule

// File: tb/tb_alif_multi_channel_core.sv
// Directed testbench for alif_multi_channel_core with hand-computed expectations.
module tb_alif_multi_channel_core;

  logic        clk = 1'b0;
  logic        reset, enable, input_enable, load_mode, serial_data;
  logic [23:0] chan_in;
  logic        spike_out, params_ready, in_refrac;
  logic [7:0]  v_mem_out;
`ifdef ALIF_SPIKE_COUNTER_EN
  logic [15:0] spike_count;
`endif

  int errors = 0;
  int checks = 0;

  alif_multi_channel_core dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .input_enable (input_enable),
    .chan_in      (chan_in),
    .load_mode    (load_mode),
    .serial_data  (serial_data),
    .spike_out    (spike_out),
    .v_mem_out    (v_mem_out),
    .params_ready (params_ready),
    .in_refrac    (in_refrac)
`ifdef ALIF_SPIKE_COUNTER_EN
    ,
    .spike_count  (spike_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] cfg(input logic [3:0] w, input logic [7:0] th,
                                      input logic [3:0] ai, input logic [2:0] ls,
                                      input logic [2:0] ds, input logic [3:0] rf);
    return {w, w, w, w, th, ai, ls, ds, rf};
  endfunction

  task automatic load_cfg(input logic [37:0] c, input int nbits);
    load_mode = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      serial_data = c[nbits-1-i];
      tick();
    end
    load_mode   = 1'b0;
    serial_data = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; input_enable = 1'b0; load_mode = 1'b0;
    serial_data = 1'b0; chan_in = '0;
    do_reset();

    // Reset state and idle UNCONFIG
    check("rst_spike", spike_out, 0);
    check("rst_v", v_mem_out, 0);
    check("rst_ready", params_ready, 0);
    check("rst_refrac", in_refrac, 0);
    check("rst_adapt", dut.adapt, 0);
    chan_in = {4{6'd16}}; input_enable = 1'b1;
    tick();
    check("unconfig_v", v_mem_out, 0);
    input_enable = 1'b0;

    // Serial load, no leak: I = 4*16*1 >> 4 = 4 per update, th = 100
    load_cfg(cfg(4'd1, 8'd100, 4'd8, 3'd0, 3'd0, 4'd3), 38);
    check("load_ready", params_ready, 1);
    check("load_v", v_mem_out, 0);
    input_enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("ramp1_v", v_mem_out, 32'(4*k));
      check("ramp1_nospike", spike_out, 0);
    end
    // Global enable low holds everything
    enable = 1'b0;
    tick(); tick();
    check("hold_v", v_mem_out, 96);
    enable = 1'b1;
    tick();
    check("spike1", spike_out, 1);
    check("spike1_v", v_mem_out, 0);
    check("spike1_refrac", in_refrac, 1);
    check("spike1_adapt", dut.adapt, 8);
    tick();
    check("refrac_a_spike", spike_out, 0);
    check("refrac_a", in_refrac, 1);
    check("refrac_a_v", v_mem_out, 0);
    tick();
    check("refrac_b", in_refrac, 1);
    tick();
    check("refrac_exit", in_refrac, 0);
    check("refrac_exit_v", v_mem_out, 0);

    // Adapted threshold 108 -> spike on 27th update
    for (int k = 1; k <= 26; k++) begin
      tick();
      check("ramp2_nospike", spike_out, 0);
    end
    check("ramp2_v", v_mem_out, 104);
    tick();
    check("spike2", spike_out, 1);
    tick(); tick(); tick();
    check("refrac2_exit", in_refrac, 0);
    for (int k = 1; k <= 5; k++) tick();
    check("pre_short_v", v_mem_out, 20);

    // Short load: 20 bits only, old parameters and v kept
    load_cfg(38'h3F_FFFF_FFFF, 20);
    check("short_ready", params_ready, 1);
    check("short_v", v_mem_out, 20);
    check("short_refrac", in_refrac, 0);
    // th now 100 + 16 = 116; v 20 needs 24 more updates
    for (int k = 1; k <= 23; k++) tick();
    check("short_ramp_v", v_mem_out, 112);
    check("short_ramp_nospike", spike_out, 0);
    tick();
    check("short_spike", spike_out, 1);
    input_enable = 1'b0;
    tick(); tick(); tick();
    check("ie_low_refrac_hold", in_refrac, 1);
    check("ie_low_nospike", spike_out, 0);

    // Reset mid-LOAD after 10 bits
    load_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      serial_data = i[0];
      tick();
    end
    load_mode = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midload_ready", params_ready, 0);
    check("midload_refrac", in_refrac, 0);
    check("midload_v", v_mem_out, 0);
    check("midload_spike", spike_out, 0);
`ifdef ALIF_SPIKE_COUNTER_EN
    check("midload_count", spike_count, 0);
`endif
    input_enable = 1'b1; chan_in = {4{6'd63}};
    tick(); tick();
    check("midload_unconfig_v", v_mem_out, 0);
    check("midload_unconfig_ready", params_ready, 0);

    // Saturation and leak: I = 4*63*15 >> 4 = 236, th = 255, leak_sh = 1
    input_enable = 1'b0;
    load_cfg(cfg(4'd15, 8'd255, 4'd0, 3'd1, 3'd0, 4'd0), 38);
    input_enable = 1'b1;
    tick();
    check("sat_u1_v", v_mem_out, 236);
    check("sat_u1_nospike", spike_out, 0);
    tick();
    check("sat_u2_spike", spike_out, 1);
    check("sat_u2_v", v_mem_out, 0);
    tick();
    check("sat_u3_v", v_mem_out, 236);

    // Adaptation decay: adapt_inc 15, decay_sh 1, refrac 0
    do_reset();
    input_enable = 1'b0;
    load_cfg(cfg(4'd15, 8'd200, 4'd15, 3'd0, 3'd1, 4'd0), 38);
    input_enable = 1'b1;
    tick();
    check("decay_spike", spike_out, 1);
    check("decay_a0", dut.adapt, 15);
    check("decay_in_refrac", in_refrac, 0);
    chan_in = '0;
    tick(); check("decay_a1", dut.adapt, 8);
    tick(); check("decay_a2", dut.adapt, 4);
    tick(); check("decay_a3", dut.adapt, 2);
    tick(); check("decay_a4", dut.adapt, 1);
    tick(); check("decay_a5", dut.adapt, 0);
    check("decay_v", v_mem_out, 0);
    check("decay_nospike", spike_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
